// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX->MEM pipeline register with stall/flush, multi-cycle temp save and stall counter
module ex_mem_stage_reg #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int ALUOP_W     = 8,
    parameter int CNT_W       = 2,
    parameter int STALL_W     = 6,
    parameter int EX_IDX      = 3,
    parameter int MEM_IDX     = 4,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [REG_ADDR_W-1:0]  ex_wd,
    input  logic                   ex_wreg,
    input  logic [DATA_W-1:0]      ex_wdata,
    input  logic [DATA_W-1:0]      ex_hi,
    input  logic [DATA_W-1:0]      ex_lo,
    input  logic                   ex_whilo,
    input  logic [ALUOP_W-1:0]     ex_aluop,
    input  logic [DATA_W-1:0]      ex_mem_addr,
    input  logic [DATA_W-1:0]      ex_sdata,
    input  logic [2*DATA_W-1:0]    hilo_i,
    input  logic [CNT_W-1:0]       cnt_i,
    output logic                   mem_valid,
    output logic [REG_ADDR_W-1:0]  mem_wd,
    output logic                   mem_wreg,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [DATA_W-1:0]      mem_hi,
    output logic [DATA_W-1:0]      mem_lo,
    output logic                   mem_whilo,
    output logic [ALUOP_W-1:0]     mem_aluop,
    output logic [DATA_W-1:0]      mem_mem_addr,
    output logic [DATA_W-1:0]      mem_sdata,
    output logic [2*DATA_W-1:0]    hilo_o,
    output logic [CNT_W-1:0]       cnt_o,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    logic ex_stall;
    logic mem_stall;
    logic unused_stall_bits;

    assign ex_stall          = stall[EX_IDX];
    assign mem_stall         = stall[MEM_IDX];
    assign unused_stall_bits = ^stall;

    // EX-stalled with MEM free inserts a bubble; both stalled freezes MEM's content.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid    <= 1'b0;
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_whilo    <= 1'b0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_sdata    <= '0;
        end else if (flush || (ex_stall && !mem_stall)) begin
            mem_valid    <= 1'b0;
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_whilo    <= 1'b0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_sdata    <= '0;
        end else if (!ex_stall) begin
            mem_valid    <= 1'b1;
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_whilo    <= ex_whilo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_sdata    <= ex_sdata;
        end
    end

    // Multi-cycle EX temporaries live only while EX is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end else if (!flush && ex_stall) begin
            hilo_o <= hilo_i;
            cnt_o  <= cnt_i;
        end else begin
            hilo_o <= '0;
            cnt_o  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (flush || !ex_stall) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb/tb_ex_mem_stage_reg.sv - self-checking bench for ex_mem_stage_reg
module tb_ex_mem_stage_reg;

    localparam int OUT_W = 1 + 5 + 1 + 32 * 3 + 1 + 8 + 32 * 2 + 64 + 2 + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0, ex_hi = '0, ex_lo = '0, ex_mem_addr = '0, ex_sdata = '0;
    logic        ex_whilo = 1'b0;
    logic [7:0]  ex_aluop = '0;
    logic [63:0] hilo_i = '0;
    logic [1:0]  cnt_i = '0;

    logic        mem_valid, mem_wreg, mem_whilo;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_sdata;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;
    logic [2:0]  stall_cnt;

    ex_mem_stage_reg #(.STALL_CNT_W(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_sdata(ex_sdata),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_sdata(mem_sdata),
        .hilo_o(hilo_o), .cnt_o(cnt_o), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    logic [OUT_W-1:0] dut_out;
    assign dut_out = {mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
                      mem_aluop, mem_mem_addr, mem_sdata, hilo_o, cnt_o, stall_cnt};

    // Reference state, advanced by the bench's own reading of the priority rules.
    logic        m_valid, m_wreg, m_whilo;
    logic [4:0]  m_wd;
    logic [31:0] m_wdata, m_hi, m_lo, m_addr, m_sdata;
    logic [7:0]  m_aluop;
    logic [63:0] m_hilo;
    logic [1:0]  m_cnt;
    logic [2:0]  m_sc;

    logic [OUT_W-1:0] sb[$];
    logic [OUT_W-1:0] exp_v;
    int n_vec = 0;
    int n_err = 0;

    always @(negedge clk)
        if (rst) assert (stall[3] || !stall[4]) else $error("illegal stall vector %b", stall);

    function automatic logic [OUT_W-1:0] model_pack();
        return {m_valid, m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo,
                m_aluop, m_addr, m_sdata, m_hilo, m_cnt, m_sc};
    endfunction

    task automatic model_clear();
        {m_valid, m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo, m_aluop, m_addr, m_sdata} = '0;
        m_hilo = '0; m_cnt = '0; m_sc = '0;
    endtask

    task automatic rand_inputs();
        ex_wd = 5'($urandom); ex_wreg = 1'($urandom); ex_wdata = $urandom;
        ex_hi = $urandom; ex_lo = $urandom; ex_whilo = 1'($urandom);
        ex_aluop = 8'($urandom); ex_mem_addr = $urandom; ex_sdata = $urandom;
        hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
    endtask

    task automatic step(input logic [5:0] st, input logic fl);
        stall = st;
        flush = fl;
        if (fl) begin
            model_clear();
        end else if (!st[3]) begin
            m_valid = 1'b1; m_wd = ex_wd; m_wreg = ex_wreg; m_wdata = ex_wdata;
            m_hi = ex_hi; m_lo = ex_lo; m_whilo = ex_whilo; m_aluop = ex_aluop;
            m_addr = ex_mem_addr; m_sdata = ex_sdata; m_hilo = '0; m_cnt = '0; m_sc = '0;
        end else begin
            if (!st[4])
                {m_valid, m_wd, m_wreg, m_wdata, m_hi, m_lo, m_whilo, m_aluop, m_addr, m_sdata} = '0;
            m_hilo = hilo_i;
            m_cnt  = cnt_i;
            if (m_sc != 3'd7) m_sc = m_sc + 3'd1;
        end
        sb.push_back(model_pack());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_vec++;
        if (dut_out !== '0) begin
            $display("FAIL reset_initial actual=%h required=0", dut_out); n_err++;
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        rand_inputs(); step(6'b000000, 1'b0);
        rand_inputs(); step(6'b001111, 1'b0);
        sb.delete();
        rand_inputs();
        #3;
        rst = 1'b0;
        #1;
        n_vec++;
        if (dut_out !== '0) begin
            $display("FAIL reset_async actual=%h required=0", dut_out); n_err++;
        end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_advance();
        rand_inputs();
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
        step(6'b000000, 1'b0);
        exp_v = sb.pop_front();
        n_vec++;
        if (dut_out !== exp_v || mem_wd !== 5'd7 || mem_wdata !== 32'hDEADBEEF || mem_valid !== 1'b1) begin
            $display("FAIL advance actual=%h required=%h", dut_out, exp_v); n_err++;
        end
    endtask

    task automatic test_multicycle();
        for (int i = 1; i <= 2; i++) begin
            hilo_i = 64'h1_00000002; cnt_i = 2'(i);
            step(6'b001111, 1'b0);
            exp_v = sb.pop_front();
            n_vec++;
            if (dut_out !== exp_v || hilo_o !== 64'h1_00000002 || cnt_o !== 2'(i)
                || stall_cnt !== 3'(i) || mem_valid !== 1'b0) begin
                $display("FAIL multicycle_%0d actual=%h required=%h", i, dut_out, exp_v); n_err++;
            end
        end
        rand_inputs();
        step(6'b000000, 1'b0);
        exp_v = sb.pop_front();
        n_vec++;
        if (dut_out !== exp_v || hilo_o !== '0 || cnt_o !== '0 || stall_cnt !== '0) begin
            $display("FAIL multicycle_release actual=%h required=%h", dut_out, exp_v); n_err++;
        end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        rand_inputs();
        held = ex_wdata;
        step(6'b000000, 1'b0);
        exp_v = sb.pop_front();
        for (int i = 1; i <= 3; i++) begin
            rand_inputs();
            step(6'b011111, 1'b0);
            exp_v = sb.pop_front();
            n_vec++;
            if (dut_out !== exp_v || mem_wdata !== held || mem_valid !== 1'b1 || stall_cnt !== 3'(i)) begin
                $display("FAIL hold_%0d actual=%h required=%h", i, dut_out, exp_v); n_err++;
            end
        end
    endtask

    task automatic test_flush();
        rand_inputs(); ex_wreg = 1'b1;
        step(6'b000000, 1'b0);
        exp_v = sb.pop_front();
        rand_inputs(); cnt_i = 2'd3;
        step(6'b011111, 1'b0);
        exp_v = sb.pop_front();
        rand_inputs(); cnt_i = 2'd3;
        step(6'b011111, 1'b1);
        exp_v = sb.pop_front();
        n_vec++;
        if (dut_out !== exp_v || mem_valid !== 1'b0 || mem_wreg !== 1'b0 || cnt_o !== '0 || stall_cnt !== '0) begin
            $display("FAIL flush_priority actual=%h required=%h", dut_out, exp_v); n_err++;
        end
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 10; i++) begin
            rand_inputs();
            step(6'b011111, 1'b0);
            exp_v = sb.pop_front();
            n_vec++;
            if (dut_out !== exp_v || stall_cnt !== ((i > 7) ? 3'd7 : 3'(i))) begin
                $display("FAIL saturation_%0d actual=%h required=%h", i, dut_out, exp_v); n_err++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] st;
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            st = 6'($urandom);
            if (!st[3]) st[4] = 1'b0;
            step(st, ($urandom_range(0, 9) == 0));
            exp_v = sb.pop_front();
            n_vec++;
            if (dut_out !== exp_v) begin
                $display("FAIL back_to_back_%0d actual=%h required=%h", i, dut_out, exp_v); n_err++;
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_advance();
        test_multicycle();
        test_hold();
        test_flush();
        test_saturation();
        test_back_to_back();
        test_reset();
        test_advance();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
